// File: rtl/dsp_fmt_pkg.sv
// Shared number-format constants and the converter state type for the
// floating-point echo-cancellation datapath.
package dsp_fmt_pkg;

    localparam int DBL_W        = 64;
    localparam int SIG16_W      = 16;
    localparam int MAG_W        = 15;
    localparam int DBL_EXP_BIAS = 1023;
    localparam int DBL_MANT_W   = 52;
    localparam int DBL_EXP_W    = 11;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } conv_state;

endpackage

// File: rtl/sig16b_to_double.sv
// Sign-magnitude 16-bit sample to IEEE-754 double, normalized one shift per
// clock and packed into a held output with a single-cycle done pulse.
module sig16b_to_double
    import dsp_fmt_pkg::*;
#(
    parameter int SAMPLE_PHASE = 0,
    parameter int EXP_BIAS     = DBL_EXP_BIAS
) (
    input  logic               clk_operation,
    input  logic               rst,
    input  logic [12:0]        sampling_cycle_counter,
    input  logic               enable,
    input  logic [SIG16_W-1:0] sig16b,
    output logic [DBL_W-1:0]   double,
    output logic               done,
    output logic               busy,
    output logic               overrun
);

    // The leading one lands in mag_r[MAG_W-1] and is implicit in IEEE form,
    // so only the bits below it reach the mantissa field.
    localparam int PAD_W = DBL_MANT_W - (MAG_W - 1);
    localparam logic [DBL_EXP_W-1:0] EXP_TOP = DBL_EXP_W'(EXP_BIAS + MAG_W - 1);

    conv_state            state;
    logic                 sign_r;
    logic                 zero_r;
    logic [MAG_W-1:0]     mag_r;
    logic [3:0]           shift_cnt;
    logic                 trigger;
    logic [DBL_EXP_W-1:0] exp_field;

    assign trigger   = (sampling_cycle_counter == 13'(SAMPLE_PHASE)) && enable;
    assign exp_field = EXP_TOP - {{(DBL_EXP_W-4){1'b0}}, shift_cnt};

    // Zero takes the NORM pass too, so every conversion costs at least two edges.
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            double    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            mag_r     <= '0;
            shift_cnt <= '0;
        end else begin
            done    <= 1'b0;
            overrun <= trigger && (state != IDLE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        sign_r    <= sig16b[SIG16_W-1];
                        mag_r     <= sig16b[MAG_W-1:0];
                        zero_r    <= (sig16b[MAG_W-1:0] == '0);
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (zero_r || mag_r[MAG_W-1]) begin
                        state <= PACK;
                    end else begin
                        mag_r     <= {mag_r[MAG_W-2:0], 1'b0};
                        shift_cnt <= shift_cnt + 4'd1;
                    end
                end
                PACK: begin
                    if (zero_r) begin
                        double <= '0;
                    end else begin
                        double <= {sign_r, exp_field, mag_r[MAG_W-2:0], {PAD_W{1'b0}}};
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig16b_to_double.sv
// Self-checking bench for sig16b_to_double: directed cases, overrun, reset
// abort, disabled trigger and a randomized run against a real-valued model.
module tb_sig16b_to_double;

    logic        clk_operation = 1'b0;
    logic        rst;
    logic [12:0] sampling_cycle_counter;
    logic        enable;
    logic [15:0] sig16b;
    logic [63:0] double;
    logic        done;
    logic        busy;
    logic        overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_operation = ~clk_operation;

    sig16b_to_double dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .sampling_cycle_counter (sampling_cycle_counter),
        .enable                 (enable),
        .sig16b                 (sig16b),
        .double                 (double),
        .done                   (done),
        .busy                   (busy),
        .overrun                (overrun)
    );

    // Reference: the sample's value as a real, encoded by the simulator itself.
    function automatic logic [63:0] model_double(input logic [15:0] s);
        real r;
        if (s[14:0] == 15'd0) return 64'h0;
        r = real'(int'(s[14:0]));
        if (s[15]) r = -r;
        return $realtobits(r);
    endfunction

    function automatic int model_latency(input logic [15:0] s);
        int m;
        int lz;
        m  = int'(s[14:0]);
        lz = 0;
        if (m == 0) return 2;
        while (m < 16384) begin
            m  = m * 2;
            lz = lz + 1;
        end
        return 2 + lz;
    endfunction

    // Behaviour of the downstream double-to-sig16b converter.
    function automatic logic [15:0] to_sig16b(input logic [63:0] d);
        int v;
        v = $rtoi($bitstoreal(d));
        if (v < 0) return {1'b1, 15'(-v)};
        return {1'b0, 15'(v)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic en);
        @(negedge clk_operation);
        sig16b                 = s;
        enable                 = en;
        sampling_cycle_counter = 13'd0;
        @(posedge clk_operation);
        #1;
        sampling_cycle_counter = 13'd7;
        enable                 = 1'b0;
        sig16b                 = 16'($urandom);
    endtask

    task automatic waitDone(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (cycles < 40) begin
            busy_cycles += int'(busy);
            @(posedge clk_operation);
            #1;
            cycles++;
            if (done) break;
        end
    endtask

    task automatic countDone(input int n_cycles, output int pulses);
        pulses = 0;
        repeat (n_cycles) begin
            @(posedge clk_operation);
            #1;
            if (done) pulses++;
        end
    endtask

    task automatic runConversion(input logic [15:0] s, input string tag);
        int c;
        int b;
        int lat;
        lat = model_latency(s);
        applyStimulus(s, 1'b1);
        waitDone(c, b);
        checkOutput({tag, " latency"}, 64'(c), 64'(lat));
        checkOutput({tag, " value"}, double, model_double(s));
        checkOutput({tag, " busy cycles"}, 64'(b), 64'(lat));
        checkOutput({tag, " busy after done"}, 64'(busy), 64'd0);
        @(posedge clk_operation);
        #1;
        checkOutput({tag, " done single pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        int b;
        int n;
        logic [15:0] s;
        logic [15:0] rt_exp;
        logic [63:0] prior;

        rst                    = 1'b1;
        sampling_cycle_counter = 13'd7;
        enable                 = 1'b0;
        sig16b                 = 16'h0;
        #12;
        checkOutput("reset double", double, 64'h0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset overrun", 64'(overrun), 64'd0);
        @(negedge clk_operation);
        rst = 1'b0;

        runConversion(16'h4000, "h4000");
        checkOutput("h4000 literal", double, 64'h40D0000000000000);
        runConversion(16'h0001, "h0001");
        checkOutput("h0001 literal", double, 64'h3FF0000000000000);
        runConversion(16'h7FFF, "h7FFF");
        checkOutput("h7FFF literal", double, 64'h40DFFFC000000000);
        runConversion(16'h8003, "h8003");
        checkOutput("h8003 literal", double, 64'hC008000000000000);
        runConversion(16'h8000, "h8000");
        checkOutput("h8000 literal", double, 64'h0);
        runConversion(16'h0000, "h0000");

        // Second trigger five edges into a 16-cycle conversion.
        applyStimulus(16'h0001, 1'b1);
        repeat (4) begin
            @(posedge clk_operation);
            #1;
        end
        sampling_cycle_counter = 13'd0;
        enable                 = 1'b1;
        @(posedge clk_operation);
        #1;
        checkOutput("overrun pulse", 64'(overrun), 64'd1);
        sampling_cycle_counter = 13'd7;
        enable                 = 1'b0;
        @(posedge clk_operation);
        #1;
        checkOutput("overrun width", 64'(overrun), 64'd0);
        c = 6;
        while (c < 40 && !done) begin
            @(posedge clk_operation);
            #1;
            c++;
        end
        checkOutput("overrun first latency", 64'(c), 64'd16);
        checkOutput("overrun first value", double, 64'h3FF0000000000000);
        countDone(20, n);
        checkOutput("overrun extra done", 64'(n), 64'd0);

        // Reset in the middle of a conversion.
        runConversion(16'h7FFF, "pre-reset");
        applyStimulus(16'h0001, 1'b1);
        repeat (3) begin
            @(posedge clk_operation);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset double", double, 64'h0);
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        @(negedge clk_operation);
        rst = 1'b0;
        countDone(20, n);
        checkOutput("aborted done", 64'(n), 64'd0);
        runConversion(16'h0002, "post-reset h0002");
        checkOutput("post-reset literal", double, 64'h4000000000000000);

        // Disabled trigger leaves the held result alone.
        prior = double;
        applyStimulus(16'h1234, 1'b0);
        countDone(20, n);
        checkOutput("disabled done", 64'(n), 64'd0);
        checkOutput("disabled hold", double, prior);
        checkOutput("disabled busy", 64'(busy), 64'd0);

        for (int i = 0; i < 200; i++) begin
            s = 16'($urandom);
            if (i == 0) s = 16'h8000;
            runConversion(s, $sformatf("rand%0d h%h", i, s));
            rt_exp = (s == 16'h8000) ? 16'h0000 : s;
            checkOutput($sformatf("roundtrip h%h", s), 64'(to_sig16b(double)), 64'(rt_exp));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
